// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the sample playback path.
//   - Default buffer address, sample and rate-divider widths.
//   - Playback reader FSM state encoding.
package sound_pkg;

  localparam int SND_ADDR_W = 10;  // 1024-entry sample buffer
  localparam int SND_DATA_W = 8;   // unsigned samples
  localparam int SND_DIV_W  = 16;  // sample-rate divider width

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    FETCH     = 2'd2,
    CAPTURE   = 2'd3
  } play_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: sample-rate tick generator.
//   clk, reset_n : clock, async active-low reset
//   run          : counter runs while high, held at 0 while low
//   rate_div     : sample period minus one (values below 2 act as 2)
//   tick         : high for one cycle every max(rate_div,2)+1 clocks
module sample_tick_gen
  import sound_pkg::*;
#(
  parameter int DIV_W = SND_DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_limit;

  // A fetch takes three cycles, so the period can never be shorter.
  assign w_limit = (rate_div < DIV_W'(2)) ? DIV_W'(2) : rate_div;

  // >= keeps the counter from running away if rate_div is lowered mid-period.
  assign tick = run && (r_cnt >= w_limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_cnt <= '0;
    else if (!run || tick) r_cnt <= '0;
    else                   r_cnt <= r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/sample_playback_reader.sv
// sample_playback_reader: paces samples out of a circular buffer RAM.
//   clk, reset_n        : clock, async active-low reset
//   enable              : run playback; low returns to IDLE and holds read_ptr
//   flush               : one-cycle pulse, read_ptr jumps to write_ptr
//   rate_div            : sample period minus one, in clocks
//   write_ptr/read_ptr  : ADDR_W+1 bit pointers, MSB is the wrap bit
//   low_thresh          : low-water level
//   read_address        : RAM read address (read_ptr without wrap bit)
//   ram_data            : RAM data, valid one cycle after its address
//   sample_out          : current sample, sample_valid pulses on update
//   level               : buffered sample count
//   low_water           : registered level <= low_thresh
//   underrun            : sticky, set on a tick with an empty buffer
//   underrun_clr        : clears underrun (a simultaneous set wins)
module sample_playback_reader
  import sound_pkg::*;
#(
  parameter int ADDR_W = SND_ADDR_W,
  parameter int DATA_W = SND_DATA_W,
  parameter int DIV_W  = SND_DIV_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [ADDR_W:0]   write_ptr,
  input  logic [ADDR_W:0]   low_thresh,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W:0]   read_ptr,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [ADDR_W:0]   level,
  output logic              low_water,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  play_state_t       r_state, w_next_state;
  logic [ADDR_W:0]   r_read_ptr;
  logic [DATA_W-1:0] r_sample_out;
  logic              r_sample_valid;
  logic              r_underrun;
  logic              r_low_water;

  logic [ADDR_W:0]   w_level;
  logic              w_empty;
  logic              w_tick;
  logic              w_run;
  logic              w_capture;
  logic              w_urun_set;

  // Modular difference of the wrap-bit pointers: 0 = empty, 2^ADDR_W = full.
  assign w_level = write_ptr - r_read_ptr;
  assign w_empty = (w_level == '0);

  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (w_run),
    .rate_div (rate_div),
    .tick     (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next state. A flush during WAIT_TICK/FETCH drops the pending fetch;
  // one during CAPTURE is handled by gating w_capture.
  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_next_state = WAIT_TICK;
        WAIT_TICK: if (w_tick && !w_empty && !flush) w_next_state = FETCH;
        FETCH:     w_next_state = flush ? WAIT_TICK : CAPTURE;
        CAPTURE:   w_next_state = WAIT_TICK;
        default:   w_next_state = IDLE;
      endcase
    end
  end

  // Control strobes. The tick counter keeps running through FETCH and
  // CAPTURE so the sample period does not stretch.
  always_comb begin
    w_run      = enable && (r_state != IDLE);
    w_capture  = enable && (r_state == CAPTURE) && !flush;
    w_urun_set = enable && (r_state == WAIT_TICK) && w_tick && w_empty;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_ptr     <= '0;
      r_sample_out   <= MIDSCALE;
      r_sample_valid <= 1'b0;
      r_underrun     <= 1'b0;
      r_low_water    <= 1'b1;
    end else begin
      if (flush)          r_read_ptr <= write_ptr;
      else if (w_capture) r_read_ptr <= r_read_ptr + 1'b1;

      if (w_capture) r_sample_out <= ram_data;
      r_sample_valid <= w_capture;

      if (w_urun_set)        r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;

      r_low_water <= (w_level <= low_thresh);
    end
  end

  assign read_address = r_read_ptr[ADDR_W-1:0];
  assign read_ptr     = r_read_ptr;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign level        = w_level;
  assign low_water    = r_low_water;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_sample_playback_reader.sv
// tb_sample_playback_reader: table-driven pointer/level vectors plus
// scoreboarded playback sequences for sample_playback_reader.
module tb_sample_playback_reader;

  logic        clk = 1'b0;
  logic        reset_n, enable, flush, underrun_clr;
  logic [15:0] rate_div;
  logic [10:0] write_ptr, low_thresh, read_ptr, level;
  logic [9:0]  read_address;
  logic [7:0]  ram_data, sample_out;
  logic        sample_valid, low_water, underrun;

  always #5 clk = ~clk;

  sample_playback_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .flush        (flush),
    .rate_div     (rate_div),
    .write_ptr    (write_ptr),
    .low_thresh   (low_thresh),
    .read_address (read_address),
    .ram_data     (ram_data),
    .read_ptr     (read_ptr),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .level        (level),
    .low_water    (low_water),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Synchronous-read sample buffer
  logic [7:0] mem [1024];
  always @(posedge clk) ram_data <= mem[read_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [10:0] fl;
    logic [10:0] wp;
    logic [10:0] th;
    logic [10:0] rp;
    logic [9:0]  ra;
    logic [10:0] lvl;
    logic        lw;
  } vec_t;
  vec_t vt[8];

  int n_vec = 0;
  int n_err = 0;
  int c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    q.push_back(e);
  endtask

  // One clock; every sample_valid pulse is matched against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sample_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got sample 0x%0h at cycle %0d, want no sample_valid",
                 sample_out, cyc);
      end else begin
        e = q.pop_front();
        chk("sample_data", 32'(sample_out), 32'(e.data));
        chk("sample_cycle", 32'(cyc), 32'(e.at));
      end
    end
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk(nm, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic set_rp(input logic [10:0] p);
    write_ptr = p;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; underrun_clr = 1'b0;
    rate_div = '0; write_ptr = '0; low_thresh = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    //          fl       wp       th       rp       ra       lvl      lw
    vt[0] = '{11'h000, 11'h000, 11'h000, 11'h000, 10'h000, 11'h000, 1'b1};
    vt[1] = '{11'h000, 11'h005, 11'h004, 11'h000, 10'h000, 11'h005, 1'b0};
    vt[2] = '{11'h000, 11'h005, 11'h005, 11'h000, 10'h000, 11'h005, 1'b1};
    vt[3] = '{11'h3FF, 11'h401, 11'h001, 11'h3FF, 10'h3FF, 11'h002, 1'b0};
    vt[4] = '{11'h7FF, 11'h000, 11'h000, 11'h7FF, 10'h3FF, 11'h001, 1'b0};
    vt[5] = '{11'h010, 11'h410, 11'h400, 11'h010, 10'h010, 11'h400, 1'b1};
    vt[6] = '{11'h400, 11'h000, 11'h3FF, 11'h400, 10'h000, 11'h400, 1'b0};
    vt[7] = '{11'h123, 11'h123, 11'h000, 11'h123, 10'h123, 11'h000, 1'b1};

    // Reset values
    step(); step();
    chk("rst_read_ptr",     32'(read_ptr),     32'h000);
    chk("rst_sample_out",   32'(sample_out),   32'h80);
    chk("rst_sample_valid", 32'(sample_valid), 32'h0);
    chk("rst_underrun",     32'(underrun),     32'h0);
    chk("rst_low_water",    32'(low_water),    32'h1);
    chk("rst_level",        32'(level),        32'h000);
    reset_n = 1'b1;
    step();

    // Pointer / level / low-water vectors, playback disabled
    for (int i = 0; i < 8; i++) begin
      set_rp(vt[i].fl);
      write_ptr  = vt[i].wp;
      low_thresh = vt[i].th;
      step();
      chk($sformatf("vec%0d_read_ptr", i),  32'(read_ptr),     32'(vt[i].rp));
      chk($sformatf("vec%0d_read_addr", i), 32'(read_address), 32'(vt[i].ra));
      chk($sformatf("vec%0d_level", i),     32'(level),        32'(vt[i].lvl));
      chk($sformatf("vec%0d_low_water", i), 32'(low_water),    32'(vt[i].lw));
    end

    // Three samples at rate_div=9: one every 10 clocks
    set_rp(11'h000);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    write_ptr = 11'h003; rate_div = 16'd9; low_thresh = '0;
    c = cyc; enable = 1'b1;
    push(8'h11, c + 13); push(8'h22, c + 23); push(8'h33, c + 33);
    wait_drain("A_drain", 60);
    chk("A_read_ptr", 32'(read_ptr), 32'h003);
    chk("A_underrun", 32'(underrun), 32'h0);
    chk("A_level",    32'(level),    32'h000);
    enable = 1'b0;
    step();

    // Empty buffer at rate_div=4: underrun, midscale held, no samples
    write_ptr = 11'h000;
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    rate_div = 16'd4;
    c = cyc; enable = 1'b1;
    step_to(c + 5);
    chk("B_underrun_pre", 32'(underrun), 32'h0);
    step_to(c + 6);
    chk("B_underrun_set", 32'(underrun),   32'h1);
    chk("B_sample_out",   32'(sample_out), 32'h80);
    underrun_clr = 1'b1;
    step_to(c + 7);
    underrun_clr = 1'b0;
    chk("B_underrun_clr", 32'(underrun), 32'h0);
    step_to(c + 9);
    underrun_clr = 1'b1;       // held across the next underrun tick
    step_to(c + 11);
    chk("B_set_over_clr", 32'(underrun), 32'h1);
    underrun_clr = 1'b0;
    enable = 1'b0;
    step();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    chk("B_underrun_final", 32'(underrun),   32'h0);
    chk("B_sample_hold",    32'(sample_out), 32'h80);

    // Address wrap 0x3FF -> 0x000, wrap bit toggles
    set_rp(11'h3FF);
    mem[10'h3FF] = 8'hA5; mem[0] = 8'h5A;
    write_ptr = 11'h401; rate_div = 16'd2;
    c = cyc; enable = 1'b1;
    push(8'hA5, c + 6); push(8'h5A, c + 9);
    wait_drain("C_drain", 30);
    chk("C_read_ptr", 32'(read_ptr), 32'h401);
    enable = 1'b0;
    step();

    // rate_div 0 and 1 clamp to a 3-clock period
    mem[1] = 8'h77; mem[2] = 8'h88;
    write_ptr = 11'h403; rate_div = 16'd0;
    c = cyc; enable = 1'b1;
    push(8'h77, c + 6); push(8'h88, c + 9);
    wait_drain("D0_drain", 30);
    chk("D0_read_ptr", 32'(read_ptr), 32'h403);
    enable = 1'b0;
    step();
    mem[3] = 8'h99;
    write_ptr = 11'h404; rate_div = 16'd1;
    c = cyc; enable = 1'b1;
    push(8'h99, c + 6);
    wait_drain("D1_drain", 30);
    chk("D1_read_ptr", 32'(read_ptr), 32'h404);
    enable = 1'b0;
    step();

    // enable dropped during FETCH: fetch discarded, restart from IDLE
    mem[4] = 8'h44;
    write_ptr = 11'h405; rate_div = 16'd0;
    c = cyc; enable = 1'b1;
    step_to(c + 4);            // FETCH cycle
    enable = 1'b0;
    step_to(c + 8);
    chk("D_abort_read_ptr", 32'(read_ptr), 32'h404);
    chk("D_abort_level",    32'(level),    32'h001);
    c = cyc; enable = 1'b1;
    push(8'h44, c + 6);        // full latency again proves a clean restart
    wait_drain("D_restart_drain", 30);
    chk("D_restart_read_ptr", 32'(read_ptr), 32'h405);
    enable = 1'b0;
    step();

    // flush in the CAPTURE cycle
    mem[5] = 8'h55;
    write_ptr = 11'h406; rate_div = 16'd2;
    c = cyc; enable = 1'b1;
    step_to(c + 5);            // CAPTURE cycle
    flush = 1'b1; write_ptr = 11'h020;
    step();
    flush = 1'b0;
    chk("E_read_ptr",   32'(read_ptr),   32'h020);
    chk("E_level",      32'(level),      32'h000);
    chk("E_sample_out", 32'(sample_out), 32'h44);
    step_to(c + 8);
    enable = 1'b0;
    step();

    // Asynchronous reset mid-FETCH
    mem[10'h020] = 8'hEE;
    write_ptr = 11'h021; low_thresh = 11'h000; rate_div = 16'd2;
    c = cyc; enable = 1'b1;
    step_to(c + 4);            // FETCH cycle
    chk("F_low_water_pre", 32'(low_water), 32'h0);
    chk("F_underrun_pre",  32'(underrun),  32'h1);
    reset_n = 1'b0;
    #1;
    chk("F_read_ptr",     32'(read_ptr),     32'h000);
    chk("F_read_addr",    32'(read_address), 32'h000);
    chk("F_sample_out",   32'(sample_out),   32'h80);
    chk("F_sample_valid", 32'(sample_valid), 32'h0);
    chk("F_underrun",     32'(underrun),     32'h0);
    chk("F_low_water",    32'(low_water),    32'h1);
    chk("F_level",        32'(level),        32'h021);
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step_to(cyc + 6);
    chk("F_sample_after", 32'(sample_out), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
